// File: rtl/ktne_switch_driver_if.sv
// ktne_switch_driver_if
// Bundles the defuser's control and switch/LED signals.
//   start  : run request, level (master -> slave)
//   abort  : return to idle (master -> slave)
//   ack    : KTNE ledG stage acknowledgements (master -> slave)
//   sw     : switch drive to KTNE {A..R} (slave -> master)
//   stage  : current or last stage index (slave -> master)
//   busy   : waiting for an ack or in the inter-stage gap (slave -> master)
//   done   : all stages acknowledged (slave -> master)
//   error  : a stage was not acknowledged in time (slave -> master)
interface ktne_switch_driver_if #(
  parameter int NUM_SW = 18
);
  logic              start;
  logic              abort;
  logic [7:0]        ack;
  logic [NUM_SW-1:0] sw;
  logic [2:0]        stage;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, abort, ack,
    input  sw, stage, busy, done, error
  );

  modport slave (
    input  start, abort, ack,
    output sw, stage, busy, done, error
  );
endinterface

// File: rtl/ktne_switch_driver.sv
// ktne_switch_driver
// Autonomous defuser: applies the KTNE switch groups in fixed stage order,
// OR-accumulating them onto sw, and advances on the bomb's green-LED ack.
// Ports:
//   clkc  : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : ktne_switch_driver_if.slave (start/abort/ack in, sw/stage/busy/done/error out)
module ktne_switch_driver #(
  parameter int NUM_SW     = 18,
  parameter int NUM_STAGES = 7,
  parameter int TIMEOUT    = 16,
  parameter int STAGE_GAP  = 2
) (
  input  logic                 clkc,
  input  logic                 reset,
  ktne_switch_driver_if.slave  bus
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W   = $clog2(STAGE_GAP + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(STAGE_GAP - 1);
  localparam logic [2:0]         LAST_STAGE = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ACK = 3'd1,
    GAP      = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4
  } state_t;

  // Switch group for each stage; groups are disjoint and cover all switches.
  function automatic logic [NUM_SW-1:0] stageMask(input logic [2:0] idx);
    logic [NUM_SW-1:0] m;
    case (idx)
      3'd0:    m = 18'h00001;  // R
      3'd1:    m = 18'h01400;  // F,H
      3'd2:    m = 18'h00808;  // O,G
      3'd3:    m = 18'h08140;  // J,C,L
      3'd4:    m = 18'h02220;  // E,I,M
      3'd5:    m = 18'h04014;  // D,P,N
      3'd6:    m = 18'h30082;  // B,A,Q,K
      default: m = 18'h00000;
    endcase
    return m;
  endfunction

  state_t              state_r, state_s;
  logic [NUM_SW-1:0]   sw_r, sw_s;
  logic [2:0]          stage_r, stage_s;
  logic [TIMER_W-1:0]  timer_r, timer_s;
  logic [GAP_W-1:0]    gap_r, gap_s;
  logic                busy_r, done_r, error_r;

  // Next-state and next-datapath decode; abort overrides every state.
  always_comb begin
    state_s = state_r;
    sw_s    = sw_r;
    stage_s = stage_r;
    timer_s = timer_r;
    gap_s   = gap_r;
    if (bus.abort) begin
      state_s = IDLE;
      sw_s    = '0;
      stage_s = 3'd0;
      timer_s = '0;
      gap_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            sw_s    = stageMask(3'd0);
            stage_s = 3'd0;
            timer_s = '0;
            state_s = WAIT_ACK;
          end else begin
            state_s = IDLE;
          end
        end
        WAIT_ACK: begin
          // Only the current stage's LED counts; ack beats timeout.
          if (bus.ack[stage_r]) begin
            if (stage_r == LAST_STAGE) begin
              state_s = DONE;
            end else begin
              stage_s = stage_r + 3'd1;
              gap_s   = '0;
              state_s = GAP;
            end
          end else if (timer_r == TIMER_LAST) begin
            state_s = ERROR;
          end else begin
            timer_s = timer_r + TIMER_W'(1);
          end
        end
        GAP: begin
          // stage already points at the group to apply next.
          if (gap_r == GAP_LAST) begin
            sw_s    = sw_r | stageMask(stage_r);
            timer_s = '0;
            state_s = WAIT_ACK;
          end else begin
            gap_s = gap_r + GAP_W'(1);
          end
        end
        DONE:    state_s = DONE;
        ERROR:   state_s = ERROR;
        default: begin
          state_s = IDLE;
          sw_s    = '0;
          stage_s = 3'd0;
          timer_s = '0;
          gap_s   = '0;
        end
      endcase
    end
  end

  // State, datapath and status flag registers.
  always_ff @(posedge clkc or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      sw_r    <= '0;
      stage_r <= 3'd0;
      timer_r <= '0;
      gap_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      sw_r    <= sw_s;
      stage_r <= stage_s;
      timer_r <= timer_s;
      gap_r   <= gap_s;
      busy_r  <= (state_s == WAIT_ACK) || (state_s == GAP);
      done_r  <= (state_s == DONE);
      error_r <= (state_s == ERROR);
    end
  end

  assign bus.sw    = sw_r;
  assign bus.stage = stage_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.error = error_r;

endmodule
